// File: rtl/usermem_arbiter.sv
// usermem_arbiter
// Shares the single 8-bit user data memory between the CPU (requester 0)
// and a second bus master (requester 1). Every access walks through
// IDLE -> ACCESS -> COMPLETE. Arbitration happens in IDLE and COMPLETE,
// so back-to-back requests sustain one access every two cycles.
//
// Build option: define ARB_FIXED_PRIO_EN to make requester 0 win every
// tie (requester 1 may starve). Default build is round-robin.
//
// All outputs are registered. Reset is asynchronous, so mem_en and the
// grants fall the moment reset rises, which keeps a half-finished write
// from reaching the memory.

module usermem_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_out,
    output logic       mem_rw,
    output logic       mem_en,
    input  logic [7:0] mem_data_in
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t state_reg;

    // Which requester owns the access currently in flight (0 or 1).
    logic owner_reg;

`ifndef ARB_FIXED_PRIO_EN
    // Last requester that was granted; the other one wins the next tie.
    logic last_grant_reg;
`endif

    logic arb_valid;
    logic arb_pick;

    // Arbitration decision, used only when the FSM is in IDLE or COMPLETE.
    always_comb begin
        arb_valid = req0 | req1;
        arb_pick  = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        arb_pick = ~req0 & req1;
`else
        if (req0 && req1) begin
            arb_pick = ~last_grant_reg;
        end else begin
            arb_pick = req1;
        end
`endif
    end

    // Grant/access/complete FSM with all bus and handshake outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_reg <= 1'b1;
`endif
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            rdata0         <= 8'h00;
            rdata1         <= 8'h00;
            busy           <= 1'b0;
            mem_address    <= 8'h00;
            mem_data_out   <= 8'h00;
            mem_rw         <= 1'b0;
            mem_en         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, COMPLETE: begin
                    // The done pulse of a finished access lasts exactly one cycle.
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (arb_valid) begin
                        state_reg      <= ACCESS;
                        owner_reg      <= arb_pick;
`ifndef ARB_FIXED_PRIO_EN
                        last_grant_reg <= arb_pick;
`endif
                        gnt0           <= ~arb_pick;
                        gnt1           <= arb_pick;
                        busy           <= 1'b1;
                        mem_en         <= 1'b1;
                        // Latch the winner's request so it may change afterwards.
                        mem_rw         <= arb_pick ? rw1    : rw0;
                        mem_address    <= arb_pick ? addr1  : addr0;
                        mem_data_out   <= arb_pick ? wdata1 : wdata0;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                ACCESS: begin
                    // Write commits at this edge in the memory; reads are captured here.
                    state_reg <= COMPLETE;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_rw    <= 1'b0;
                    done0     <= ~owner_reg;
                    done1     <= owner_reg;
                    if (!mem_rw) begin
                        if (owner_reg) begin
                            rdata1 <= mem_data_in;
                        end else begin
                            rdata0 <= mem_data_in;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                    busy      <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_rw    <= 1'b0;
                end
            endcase
        end
    end

endmodule
